// File: rtl/memory_writeback_stage.sv
// EX/MEM + MEM/WB stage: issues data-memory loads/stores over req/ack and registers the write-back bundle.
// Optional MEM_TIMEOUT_EN adds memTimeout and abandons a memory access after TIMEOUT_CYCLES without memAck.
module memory_writeback_stage #(
    parameter int         ADDR_W         = 8,
    parameter logic [3:0] OP_LOAD        = 4'h8,
    parameter logic [3:0] OP_STORE       = 4'h9,
    parameter logic [3:0] OP_BEQ         = 4'hA,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              exValid,
    output logic              exReady,
    input  logic [19:0]       instruction,
    input  logic [19:0]       result,
    input  logic              ulaZero,
    input  logic [19:0]       dataRFOut2,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [19:0]       memWData,
    input  logic              memAck,
    input  logic [19:0]       memRData,
    output logic              wbValid,
    output logic              wbWriteEn,
    output logic [3:0]        wbReg,
    output logic [19:0]       wbData,
    output logic              wbZero,
    output logic [19:0]       wbInstruction
`ifdef MEM_TIMEOUT_EN
    ,output logic             memTimeout
`endif
);

    typedef enum logic {IDLE, MEM_WAIT} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [19:0] r_instr;
    logic [19:0] r_result;
    logic        r_zero;
    logic        w_transfer;
    logic        w_isMem;
    logic        w_timeout;
    logic [3:0]  w_opcode;

    assign w_opcode = instruction[19:16];
    assign w_isMem  = (w_opcode == OP_LOAD) || (w_opcode == OP_STORE);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_count;

    // Counts MEM_WAIT cycles without an ack; the limit is reached on the TIMEOUT_CYCLES-th such cycle.
    assign w_timeout = (r_state == MEM_WAIT) && !memAck && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count    <= '0;
            memTimeout <= 1'b0;
        end else begin
            memTimeout <= w_timeout;
            if (w_transfer)
                r_count <= '0;
            else if (r_state == MEM_WAIT && !memAck)
                r_count <= r_count + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_transfer && w_isMem) w_nextState = MEM_WAIT;
            MEM_WAIT: if (memAck || w_timeout)   w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    always_comb begin
        exReady    = (r_state == IDLE);
        w_transfer = exValid && exReady;
    end

    // Memory request and write-back registers; wb* fields hold when wbValid is low.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_instr       <= '0;
            r_result      <= '0;
            r_zero        <= 1'b0;
            memReq        <= 1'b0;
            memWe         <= 1'b0;
            memAddr       <= '0;
            memWData      <= '0;
            wbValid       <= 1'b0;
            wbWriteEn     <= 1'b0;
            wbReg         <= '0;
            wbData        <= '0;
            wbZero        <= 1'b0;
            wbInstruction <= '0;
        end else begin
            wbValid <= 1'b0;
            if (w_transfer) begin
                if (w_isMem) begin
                    r_instr  <= instruction;
                    r_result <= result;
                    r_zero   <= ulaZero;
                    memReq   <= 1'b1;
                    memWe    <= (w_opcode == OP_STORE);
                    memAddr  <= result[ADDR_W-1:0];
                    memWData <= dataRFOut2;
                end else begin
                    wbValid       <= 1'b1;
                    wbWriteEn     <= (w_opcode != OP_BEQ);
                    wbReg         <= instruction[15:12];
                    wbData        <= result;
                    wbZero        <= ulaZero;
                    wbInstruction <= instruction;
                end
            end else if (r_state == MEM_WAIT) begin
                if (memAck) begin
                    memReq        <= 1'b0;
                    wbValid       <= 1'b1;
                    wbReg         <= r_instr[15:12];
                    wbZero        <= r_zero;
                    wbInstruction <= r_instr;
                    if (r_instr[19:16] == OP_LOAD) begin
                        wbData    <= memRData;
                        wbWriteEn <= 1'b1;
                    end else begin
                        wbData    <= r_result;
                        wbWriteEn <= 1'b0;
                    end
                end else if (w_timeout) begin
                    memReq <= 1'b0;
                end
            end
        end
    end

endmodule
